// File: rtl/serial_alu32_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_alu32_pkg
// Brief    : Control codes, FSM state type and helpers for serial_alu32.
// Revision : 1.0
// ============================================================================
package serial_alu32_pkg;

    localparam logic [2:0] ALU_UADD  = 3'd0;
    localparam logic [2:0] ALU_ADDNB = 3'd1;  // A + ~B, carry-in 0
    localparam logic [2:0] ALU_ADD   = 3'd2;
    localparam logic [2:0] ALU_SUB   = 3'd3;
    localparam logic [2:0] ALU_AND   = 3'd4;
    localparam logic [2:0] ALU_OR    = 3'd5;
    localparam logic [2:0] ALU_NOR   = 3'd6;
    localparam logic [2:0] ALU_XOR   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_signed_arith(input logic [2:0] ctrl);
        return (ctrl == ALU_ADD) || (ctrl == ALU_SUB) || (ctrl == ALU_ADDNB);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_alu32_alu1.sv
`default_nettype none
// ============================================================================
// Module   : alu1
// Brief    : One-bit ALU slice; arithmetic codes share a full adder.
// Revision : 1.0
// ============================================================================
module alu1
    import serial_alu32_pkg::*;
(
    input  logic       a_i,
    input  logic       b_i,
    input  logic       cin_i,
    input  logic [2:0] control_i,
    output logic       result_o,
    output logic       cout_o
);

    logic w_b;
    logic w_sum;

    // B is inverted only for the subtract-style codes 1 and 3
    assign w_b    = b_i ^ (control_i[0] & ~control_i[2]);
    assign w_sum  = a_i ^ w_b ^ cin_i;
    assign cout_o = (a_i & w_b) | (a_i & cin_i) | (w_b & cin_i);

    always_comb begin
        result_o = w_sum;
        case (control_i)
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_NOR: result_o = ~(a_i | b_i);
            ALU_XOR: result_o = a_i ^ b_i;
            default: result_o = w_sum;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/serial_alu32.sv
`default_nettype none
// ============================================================================
// Module   : serial_alu32
// Brief    : Bit-serial ALU sequencer driving one alu1 slice LSB-first.
//            Optional flag outputs enabled by macro SERIAL_ALU_FLAGS_EN.
// Revision : 1.0
// ============================================================================
module serial_alu32
    import serial_alu32_pkg::*;
#(
    parameter int WIDTH = 32
)
(
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out
`ifdef SERIAL_ALU_FLAGS_EN
    ,
    output logic             overflow,
    output logic             zero,
    output logic             negative
`endif
);

    localparam int CW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic [2:0]       ctrl_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             w_bit, w_cout, w_accept, w_last;

    assign w_accept = in_valid && (state_q == IDLE);
    assign w_last   = (cnt_q == CW'(WIDTH - 1));

    alu1 u_alu1 (
        .a_i       (a_q[0]),
        .b_i       (b_q[0]),
        .cin_i     (carry_q),
        .control_i (ctrl_q),
        .result_o  (w_bit),
        .cout_o    (w_cout)
    );

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (w_last)    state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            ctrl_q  <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
        end else if (w_accept) begin
            a_q     <= A;
            b_q     <= B;
            ctrl_q  <= control;
            cnt_q   <= '0;
            // code 1 shares the inverted-B path with SUB but starts carry at 0
            carry_q <= (control == ALU_SUB);
        end else if (state_q == RUN) begin
            a_q     <= a_q >> 1;
            b_q     <= b_q >> 1;
            res_q   <= {w_bit, res_q[WIDTH-1:1]};
            carry_q <= w_cout;
            cnt_q   <= cnt_q + CW'(1);
        end
    end

    assign out = res_q;

`ifdef SERIAL_ALU_FLAGS_EN
    logic ovf_q, zero_q, neg_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else if (w_accept) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b1;
            neg_q  <= 1'b0;
        end else if (state_q == RUN) begin
            if (w_bit) zero_q <= 1'b0;
            // on the MSB cycle carry_q is the carry into the MSB
            if (w_last) begin
                ovf_q <= is_signed_arith(ctrl_q) & (carry_q ^ w_cout);
                neg_q <= w_bit;
            end
        end
    end

    assign overflow = ovf_q;
    assign zero     = zero_q;
    assign negative = neg_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_alu32.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_alu32
// Brief    : Scoreboard bench for serial_alu32 with directed vectors.
// Revision : 1.0
// ============================================================================
module tb_serial_alu32;

    localparam int WIDTH = 32;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic [2:0]       control = 3'd0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out;
`ifdef SERIAL_ALU_FLAGS_EN
    logic             overflow, zero, negative;
`endif

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             ovf;
        logic             zf;
        logic             nf;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    serial_alu32 #(.WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .control   (control),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
`ifdef SERIAL_ALU_FLAGS_EN
        ,
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pop one expected result per completed output handshake
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 64'(out), 64'hDEAD);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", 64'(out), 64'(e.res));
`ifdef SERIAL_ALU_FLAGS_EN
                check("overflow", 64'(overflow), 64'(e.ovf));
                check("zero", 64'(zero), 64'(e.zf));
                check("negative", 64'(negative), 64'(e.nf));
`endif
            end
        end
    end

    task automatic issue(input logic [2:0] c, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clock); #1;
            guard++;
        end
        check("in_ready_wait", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        A        = a;
        B        = b;
        control  = c;
        @(posedge clock); #1;
        // scramble inputs: they must not affect the running operation
        in_valid = 1'b0;
        A        = $urandom;
        B        = $urandom;
        control  = 3'($urandom_range(0, 7));
        check("in_ready_low_after_accept", 64'(in_ready), 64'd0);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        check("latency", 64'(n), 64'(WIDTH));
    endtask

    task automatic do_op(input logic [2:0] c, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] r, input logic v, input logic z, input logic ng);
        sb.push_back('{res: r, ovf: v, zf: z, nf: ng});
        issue(c, a, b);
        wait_valid();
        @(posedge clock); #1;
        check("in_ready_after_take", 64'(in_ready), 64'd1);
        check("out_valid_after_take", 64'(out_valid), 64'd0);
    endtask

    initial begin
        int seen;
        repeat (3) @(posedge clock);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out", 64'(out), 64'd0);
`ifdef SERIAL_ALU_FLAGS_EN
        check("rst_flags", 64'({overflow, zero, negative}), 64'd0);
`endif
        // in_valid alongside reset must be ignored
        in_valid = 1'b1;
        A        = 32'd1;
        B        = 32'd1;
        @(posedge clock); #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        @(posedge clock); #1;
        check("in_valid_with_reset_ignored", 64'(in_ready), 64'd1);

        do_op(3'd2, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, 1'b0, 1'b1); // ADD
        do_op(3'd3, 32'd5,         32'd5,         32'h0000_0000, 1'b0, 1'b1, 1'b0); // SUB
        do_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, 1'b0); // UADD
        do_op(3'd6, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'hF000_F000, 1'b0, 1'b0, 1'b1); // NOR
        do_op(3'd1, 32'd10,        32'd3,         32'd6,         1'b0, 1'b0, 1'b0); // A+~B
        do_op(3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b1); // AND
        do_op(3'd5, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b0); // OR
        do_op(3'd3, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0); // SUB ovf

        // Backpressure: result must hold while out_ready is low
        out_ready = 1'b0;
        sb.push_back('{res: 32'd7, ovf: 1'b0, zf: 1'b0, nf: 1'b0});
        issue(3'd2, 32'd3, 32'd4);
        wait_valid();
        in_valid = 1'b1;
        A        = 32'd99;
        B        = 32'd1;
        control  = 3'd2;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            check("stall_out", 64'(out), 64'd7);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clock); #1;
        check("stall_in_ready_after_take", 64'(in_ready), 64'd1);
        repeat (3) @(posedge clock);
        #1;
        check("stall_no_extra_op", 64'(out_valid), 64'd0);

        // Reset during RUN cycle 15 aborts the request
        issue(3'd2, 32'd1, 32'd2);
        repeat (14) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (out_valid) seen++;
        end
        check("abort_no_output", 64'(seen), 64'd0);

        do_op(3'd7, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555, 1'b0, 1'b0, 1'b0); // XOR

        repeat (2) @(posedge clock);
        #1;
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
